uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO, optional runtime-selectable parity and configurable data/stop-bit widths. It sits between the bus-side register interface and the TX pin. The host pushes characters into the FIFO. Frames are serialised one bit per baud event, derived from the rising edge of `clk_tx`, with back-to-back frames and no idle gap while the FIFO holds data.

## Interface
Parameters:
- `WIDTH_DATA`, 8: data bits per frame; legal range 5..9.
- `NB_STOP`, 2: stop bits per frame; legal values 1 or 2.
- `DEPTH`, 8: FIFO entries; must be a power of 2, minimum 2.

Ports. One clock; reset is asynchronous and active-low (`i_clk`, `i_nrst`).
- `i_clk`, in, 1: system clock.
- `i_nrst`, in, 1: asynchronous active-low reset.
- `clk_tx`, in, 1: baud clock, synchronous to `i_clk`; each rising edge is one bit period.
- `i_we`, in, 1: push strobe.
- `i_data`, in, `WIDTH_DATA`: character to push.
- `i_par_en`, in, 1: parity enable.
- `i_par_odd`, in, 1: 1 = odd parity, 0 = even parity.
- `o_buf`, out, 1: TX line; idle high.
- `o_mty`, out, 1: FIFO empty and FSM idle.
- `o_full`, out, 1: FIFO full.
- `o_ovf`, out, 1: one-cycle pulse when a push is dropped.

## Operation
- **Baud event detection.**
  - Two-flop shift: `s1 <= clk_tx; s0 <= s1`.
  - `ev = s1 & ~s0`, so `ev` is high for exactly one `i_clk` cycle per rising edge.
  - All FSM and `o_buf` updates happen only on cycles with `ev = 1`.
- **FIFO.**
  - A push (`i_we & ~o_full`) writes `i_data` at the write pointer.
  - `i_we & o_full` drops the data and pulses `o_ovf`. This holds even if a pop occurs in the same cycle, because `o_full` is evaluated from registered state.
  - Pop happens only from the FSM (see below). Simultaneous push and pop keeps the count unchanged.
  - Pointers are `log2(DEPTH)` bits and wrap. The count is `log2(DEPTH)+1` bits.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE, on `ev` with FIFO non-empty:
    - Pop the head into the shift register.
    - Latch `i_par_en` and `i_par_odd` for the frame.
    - Clear the parity accumulator; set `o_buf <= 0`; go to START.
  - START, on `ev`: `o_buf <= sh[0]`, shift right (fill with 1), bit counter = 1, go to DATA.
  - DATA, on `ev`:
    - If bit counter < `WIDTH_DATA`: output the next bit and increment the counter.
    - Else, if parity is latched enabled: `o_buf <= ^data ^ odd`, go to PARITY.
    - Else: `o_buf <= 1`, stop counter = 1, go to STOP.
  - PARITY, on `ev`: `o_buf <= 1`, stop counter = 1, go to STOP.
  - STOP, on `ev`:
    - If stop counter < `NB_STOP`: keep `o_buf = 1` and increment the counter.
    - Else, if FIFO non-empty: perform the IDLE-start action directly (pop, `o_buf <= 0`, go to START). Frames run back-to-back.
    - Else: go to IDLE with `o_buf = 1`.
- Frame length is `1 + WIDTH_DATA + P + NB_STOP` bit periods, where P = latched `i_par_en`.
- `o_mty = (count == 0) & (state == IDLE)`, combinational from registers.
- Reset mid-frame: the frame is aborted immediately, `o_buf` returns to 1 asynchronously and the FIFO contents are discarded.

## Timing
- **Reset values:** `o_buf` = 1, `o_mty` = 1, `o_full` = 0, `o_ovf` = 0; state IDLE; FIFO count 0; `s1`/`s0` = 0.
- **Event latency:** a rising edge of `clk_tx` at `i_clk` cycle n gives `ev` at cycle n+1 and the `o_buf` change at cycle n+2.
- **Push visibility:** a push in cycle c is visible to the FSM from cycle c+1. A push coinciding with `ev` while IDLE and empty waits for the next `ev`.
- **Flag latency:** `o_full` and `o_mty` update one cycle after the causing push or pop.
- **Parity mode:** `i_par_en` and `i_par_odd` changes mid-frame have no effect on the frame in progress.

## Structure
- **Shared package `uart_pkg`:**
  - state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants;
  - `clog2` helper for FIFO pointer width.
- **Sub-module `uart_sync_fifo`:**
  - parameters `WIDTH`, `DEPTH`;
  - ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `ovf`;
  - reused by the future RX path.
- Edge detector, FSM, shift register and parity accumulator stay in the top module.

## Test plan
- **Reset idle:** assert `i_nrst` low, release, toggle `clk_tx` 20 times → `o_buf` stays 1, `o_mty` = 1, `o_full` = 0.
- **Single frame, even parity:** `WIDTH_DATA` = 8, `NB_STOP` = 2, `i_par_en` = 1, `i_par_odd` = 0, push 0xA5 → line carries 0, 1,0,1,0,0,1,0,1, parity 0, 1, 1 (12 bit periods); `o_mty` returns to 1 after the last stop event.
- **Back-to-back frames:** `i_par_en` = 0, push 0x00 then 0xFF → no idle gap; the second start bit follows the second stop bit at the next `ev`; total 22 bit periods.
- **Overflow:** `DEPTH` = 4, hold `clk_tx` static, push 5 values → `o_full` = 1 after the 4th push; 5th push pulses `o_ovf` once; transmitted data is exactly the first 4 values in order.
- **Odd parity with 5-bit data:** `WIDTH_DATA` = 5, `NB_STOP` = 1, `i_par_odd` = 1, push 0x00 → parity bit 1; frame length 8 bit periods.
- **Reset mid-frame:** pull `i_nrst` low during the 3rd data bit with 2 entries queued → `o_buf` = 1 immediately; after release `o_mty` = 1 and no further frames are sent.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART blocks: transmitter state
//                encoding, parity mode constants and a constant-evaluable
//                ceil(log2) helper used to size FIFO pointers and counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmitter frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Values of the parity-odd selector.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  // Written as a bounded loop so it can be evaluated at elaboration time.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Single-clock FIFO with registered occupancy count,
//                combinational (first-word-fall-through) read data and a
//                registered one-cycle overflow pulse for dropped pushes.
//                Shared by the UART transmit path and the future receive path.
//
//  Ports
//    clk    in   1      clock
//    rst_n  in   1      asynchronous active-low reset (empties the FIFO)
//    push   in   1      write request; ignored when full
//    pop    in   1      read request; ignored when empty
//    din    in   WIDTH  write data
//    dout   out  WIDTH  head-of-queue data (valid while empty = 0)
//    full   out  1      count == DEPTH
//    empty  out  1      count == 0
//    ovf    out  1      one-cycle pulse after a push was dropped
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             ovf_q;
  logic             wr_en;
  logic             rd_en;

  // Flags come from registered state only, so a push into a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];
  assign ovf   = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= push & full;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : UART transmitter with an internal transmit FIFO. Characters
//                pushed by the host are serialised LSB first as
//                start / data / optional parity / stop bits, one bit per
//                rising edge of the baud clock clk_tx. Frames run
//                back-to-back while the FIFO holds data.
//
//  Ports
//    i_clk      in   1           system clock
//    i_nrst     in   1           asynchronous active-low reset
//    clk_tx     in   1           baud clock (synchronous to i_clk)
//    i_we       in   1           push strobe
//    i_data     in   WIDTH_DATA  character to push
//    i_par_en   in   1           parity enable (latched per frame)
//    i_par_odd  in   1           1 = odd, 0 = even parity (latched per frame)
//    o_buf      out  1           TX line, idle high
//    o_mty      out  1           FIFO empty and sequencer idle
//    o_full     out  1           FIFO full
//    o_ovf      out  1           one-cycle pulse when a push is dropped
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH_DATA = 8,
  parameter int NB_STOP    = 2,
  parameter int DEPTH      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  clk_tx,
  input  logic                  i_we,
  input  logic [WIDTH_DATA-1:0] i_data,
  input  logic                  i_par_en,
  input  logic                  i_par_odd,
  output logic                  o_buf,
  output logic                  o_mty,
  output logic                  o_full,
  output logic                  o_ovf
);

  // Counters are sized to hold their terminal value (WIDTH_DATA, NB_STOP).
  localparam int BW = clog2(WIDTH_DATA + 1);
  localparam int SW = clog2(NB_STOP + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH_DATA);
  localparam logic [SW-1:0] STOP_LAST = SW'(NB_STOP);

  // --------------------------------------------------------------------------
  // Baud event: one i_clk-wide pulse per rising edge of clk_tx.
  // --------------------------------------------------------------------------
  logic s1;
  logic s0;
  logic ev;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s1 <= 1'b0;
      s0 <= 1'b0;
    end else begin
      s1 <= clk_tx;
      s0 <= s1;
    end
  end

  assign ev = s1 & ~s0;

  // --------------------------------------------------------------------------
  // Transmit FIFO
  // --------------------------------------------------------------------------
  logic                  pop;
  logic [WIDTH_DATA-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_ovf;

  uart_sync_fifo #(
    .WIDTH (WIDTH_DATA),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_nrst),
    .push  (i_we),
    .pop   (pop),
    .din   (i_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ovf   (fifo_ovf)
  );

  // --------------------------------------------------------------------------
  // Frame sequencer: registers
  // --------------------------------------------------------------------------
  tx_state_t             state,     state_nxt;
  logic [WIDTH_DATA-1:0] sh,        sh_nxt;
  logic [BW-1:0]         bit_cnt,   bit_cnt_nxt;
  logic [SW-1:0]         stop_cnt,  stop_cnt_nxt;
  logic                  par_acc,   par_acc_nxt;
  logic                  par_en_q,  par_en_nxt;
  logic                  par_odd_q, par_odd_nxt;
  logic                  tx_q,      tx_nxt;
  logic                  start_frame;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= ST_IDLE;
      sh        <= '1;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      par_acc   <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state     <= state_nxt;
      sh        <= sh_nxt;
      bit_cnt   <= bit_cnt_nxt;
      stop_cnt  <= stop_cnt_nxt;
      par_acc   <= par_acc_nxt;
      par_en_q  <= par_en_nxt;
      par_odd_q <= par_odd_nxt;
      tx_q      <= tx_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Frame sequencer: next state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    sh_nxt       = sh;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    par_acc_nxt  = par_acc;
    par_en_nxt   = par_en_q;
    par_odd_nxt  = par_odd_q;
    tx_nxt       = tx_q;
    pop          = 1'b0;
    start_frame  = 1'b0;

    if (ev) begin
      case (state)
        ST_IDLE: begin
          start_frame = ~fifo_empty;
        end

        // Start bit has just finished: put data bit 0 on the line.
        ST_START: begin
          tx_nxt      = sh[0];
          par_acc_nxt = par_acc ^ sh[0];
          sh_nxt      = {1'b1, sh[WIDTH_DATA-1:1]};
          bit_cnt_nxt = BW'(1);
          state_nxt   = ST_DATA;
        end

        // bit_cnt counts data bits already placed on the line.
        ST_DATA: begin
          if (bit_cnt < BIT_LAST) begin
            tx_nxt      = sh[0];
            par_acc_nxt = par_acc ^ sh[0];
            sh_nxt      = {1'b1, sh[WIDTH_DATA-1:1]};
            bit_cnt_nxt = bit_cnt + 1'b1;
          end else if (par_en_q) begin
            // Accumulator holds the XOR of all data bits (even parity).
            tx_nxt    = par_acc ^ (par_odd_q == PAR_ODD);
            state_nxt = ST_PARITY;
          end else begin
            tx_nxt       = 1'b1;
            stop_cnt_nxt = SW'(1);
            state_nxt    = ST_STOP;
          end
        end

        ST_PARITY: begin
          tx_nxt       = 1'b1;
          stop_cnt_nxt = SW'(1);
          state_nxt    = ST_STOP;
        end

        // stop_cnt counts stop bit periods already started.
        ST_STOP: begin
          if (stop_cnt < STOP_LAST) begin
            tx_nxt       = 1'b1;
            stop_cnt_nxt = stop_cnt + 1'b1;
          end else if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end

        default: begin
          tx_nxt    = 1'b1;
          state_nxt = ST_IDLE;
        end
      endcase

      // Frame launch, shared by IDLE and the back-to-back path out of STOP:
      // take the FIFO head, freeze parity mode for the whole frame and drive
      // the start bit.
      if (start_frame) begin
        pop         = 1'b1;
        sh_nxt      = fifo_dout;
        par_en_nxt  = i_par_en;
        par_odd_nxt = i_par_odd;
        par_acc_nxt = 1'b0;
        tx_nxt      = 1'b0;
        state_nxt   = ST_START;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_buf  = tx_q;
  assign o_mty  = fifo_empty & (state == ST_IDLE);
  assign o_full = fifo_full;
  assign o_ovf  = fifo_ovf;

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed self-checking bench for uart_tx_fifo. Instance A
//                uses 8 data bits / 2 stop bits / 4-entry FIFO, instance B
//                uses 5 data bits / 1 stop bit / 4-entry FIFO. Each baud()
//                call produces one full clk_tx period; the line is sampled
//                after it, so each sample is one transmitted bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic       clk;
  logic       nrst;
  logic       clk_tx;
  logic       par_en;
  logic       par_odd;

  logic       we_a;
  logic [7:0] data_a;
  logic       buf_a, mty_a, full_a, ovf_a;

  logic       we_b;
  logic [4:0] data_b;
  logic       buf_b, mty_b, full_b, ovf_b;

  int checks;
  int errors;

  uart_tx_fifo #(
    .WIDTH_DATA (8),
    .NB_STOP    (2),
    .DEPTH      (4)
  ) dut_a (
    .i_clk     (clk),
    .i_nrst    (nrst),
    .clk_tx    (clk_tx),
    .i_we      (we_a),
    .i_data    (data_a),
    .i_par_en  (par_en),
    .i_par_odd (par_odd),
    .o_buf     (buf_a),
    .o_mty     (mty_a),
    .o_full    (full_a),
    .o_ovf     (ovf_a)
  );

  uart_tx_fifo #(
    .WIDTH_DATA (5),
    .NB_STOP    (1),
    .DEPTH      (4)
  ) dut_b (
    .i_clk     (clk),
    .i_nrst    (nrst),
    .clk_tx    (clk_tx),
    .i_we      (we_b),
    .i_data    (data_b),
    .i_par_en  (par_en),
    .i_par_odd (par_odd),
    .o_buf     (buf_b),
    .o_mty     (mty_b),
    .o_full    (full_b),
    .o_ovf     (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bit period: clk_tx high 4 cycles, low 4 cycles; returns 1 time unit
  // after a rising i_clk edge, well after the line has settled.
  task automatic baud();
    @(posedge clk); #1;
    clk_tx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    clk_tx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] v);
    @(posedge clk); #1;
    we_a   = 1'b1;
    data_a = v;
    @(posedge clk); #1;
    we_a   = 1'b0;
  endtask

  task automatic push_b(input logic [4:0] v);
    @(posedge clk); #1;
    we_b   = 1'b1;
    data_b = v;
    @(posedge clk); #1;
    we_b   = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; clk_tx = 1'b0; par_en = 1'b0; par_odd = 1'b0;
    we_a = 1'b0; data_a = '0; we_b = 1'b0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (buf_a !== 1'b1) begin errors++; $display("FAIL reset_buf_a: got %b expected 1", buf_a); end
    checks++; if (mty_a !== 1'b1) begin errors++; $display("FAIL reset_mty_a: got %b expected 1", mty_a); end
    checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL reset_full_a: got %b expected 0", full_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf_a: got %b expected 0", ovf_a); end
    checks++; if (buf_b !== 1'b1) begin errors++; $display("FAIL reset_buf_b: got %b expected 1", buf_b); end
    checks++; if (mty_b !== 1'b1) begin errors++; $display("FAIL reset_mty_b: got %b expected 1", mty_b); end
    nrst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      baud();
      checks++;
      if (buf_a !== 1'b1 || buf_b !== 1'b1) begin
        errors++; $display("FAIL idle_line[%0d]: got a=%b b=%b expected 1", i, buf_a, buf_b);
      end
    end
    checks++; if (mty_a !== 1'b1) begin errors++; $display("FAIL idle_mty: got %b expected 1", mty_a); end
    checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL idle_full: got %b expected 0", full_a); end
  endtask

  task automatic test_even_parity();
    // Sent order bit0..bit11: start, A5 LSB first, parity 0, stop, stop.
    logic [11:0] exp;
    exp = 12'b1101_0100_1010;
    par_en = 1'b1; par_odd = 1'b0;
    push_a(8'hA5);
    checks++; if (mty_a !== 1'b0) begin errors++; $display("FAIL even_mty_after_push: got %b expected 0", mty_a); end
    for (int i = 0; i < 12; i++) begin
      baud();
      checks++;
      if (buf_a !== exp[i]) begin
        errors++; $display("FAIL even_bit[%0d]: got %b expected %b", i, buf_a, exp[i]);
      end
    end
    baud();
    checks++; if (mty_a !== 1'b1) begin errors++; $display("FAIL even_mty_end: got %b expected 1", mty_a); end
    checks++; if (buf_a !== 1'b1) begin errors++; $display("FAIL even_line_end: got %b expected 1", buf_a); end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp;
    exp = {2'b11, 8'hFF, 1'b0, 2'b11, 8'h00, 1'b0};
    par_en = 1'b0; par_odd = 1'b0;
    push_a(8'h00);
    push_a(8'hFF);
    for (int i = 0; i < 22; i++) begin
      baud();
      checks++;
      if (buf_a !== exp[i]) begin
        errors++; $display("FAIL b2b_bit[%0d]: got %b expected %b", i, buf_a, exp[i]);
      end
    end
    baud();
    checks++; if (mty_a !== 1'b1 || buf_a !== 1'b1) begin
      errors++; $display("FAIL b2b_end: got mty=%b line=%b expected 1 1", mty_a, buf_a);
    end
  endtask

  task automatic test_overflow();
    logic [43:0] exp;
    int          ovf_cnt;
    exp = {2'b11, 8'h44, 1'b0, 2'b11, 8'h33, 1'b0,
           2'b11, 8'h22, 1'b0, 2'b11, 8'h11, 1'b0};
    par_en = 1'b0;
    push_a(8'h11);
    push_a(8'h22);
    push_a(8'h33);
    checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL ovf_full_3: got %b expected 0", full_a); end
    push_a(8'h44);
    checks++; if (full_a !== 1'b1) begin errors++; $display("FAIL ovf_full_4: got %b expected 1", full_a); end
    // Fifth push: count overflow pulses in a window around the dropped push.
    ovf_cnt = 0;
    @(posedge clk); #1;
    we_a = 1'b1; data_a = 8'h55;
    @(negedge clk); if (ovf_a === 1'b1) ovf_cnt++;
    @(posedge clk); #1;
    we_a = 1'b0;
    repeat (3) begin
      @(negedge clk); if (ovf_a === 1'b1) ovf_cnt++;
    end
    checks++; if (ovf_cnt != 1) begin errors++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_cnt); end
    checks++; if (full_a !== 1'b1) begin errors++; $display("FAIL ovf_full_5: got %b expected 1", full_a); end
    for (int i = 0; i < 44; i++) begin
      baud();
      checks++;
      if (buf_a !== exp[i]) begin
        errors++; $display("FAIL ovf_bit[%0d]: got %b expected %b", i, buf_a, exp[i]);
      end
      if (i == 0) begin
        checks++; if (full_a !== 1'b0) begin errors++; $display("FAIL ovf_full_after_pop: got %b expected 0", full_a); end
      end
    end
    baud();
    checks++; if (mty_a !== 1'b1 || buf_a !== 1'b1) begin
      errors++; $display("FAIL ovf_end: got mty=%b line=%b expected 1 1", mty_a, buf_a);
    end
  endtask

  task automatic test_odd_parity_5bit();
    // start, 5 zeros, parity 1, stop.
    logic [7:0] exp;
    exp = 8'b1100_0000;
    par_en = 1'b1; par_odd = 1'b1;
    push_b(5'h00);
    for (int i = 0; i < 8; i++) begin
      baud();
      // Flipping the mode mid-frame must not alter this frame's parity.
      if (i == 0) par_odd = 1'b0;
      checks++;
      if (buf_b !== exp[i]) begin
        errors++; $display("FAIL odd5_bit[%0d]: got %b expected %b", i, buf_b, exp[i]);
      end
    end
    baud();
    checks++; if (mty_b !== 1'b1 || buf_b !== 1'b1) begin
      errors++; $display("FAIL odd5_end: got mty=%b line=%b expected 1 1", mty_b, buf_b);
    end
    par_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    par_en = 1'b0; par_odd = 1'b0;
    push_a(8'hF0);
    push_a(8'h12);
    push_a(8'h34);
    // start, d0, d1, d2: now inside the 3rd data bit (0 for 0xF0).
    repeat (4) baud();
    checks++; if (buf_a !== 1'b0) begin errors++; $display("FAIL midrst_before: got %b expected 0", buf_a); end
    @(posedge clk); #3;
    nrst = 1'b0;
    #1;
    checks++; if (buf_a !== 1'b1) begin errors++; $display("FAIL midrst_line_async: got %b expected 1", buf_a); end
    checks++; if (mty_a !== 1'b1) begin errors++; $display("FAIL midrst_mty_async: got %b expected 1", mty_a); end
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      baud();
      checks++;
      if (buf_a !== 1'b1) begin
        errors++; $display("FAIL midrst_idle[%0d]: got %b expected 1", i, buf_a);
      end
    end
    checks++; if (mty_a !== 1'b1) begin errors++; $display("FAIL midrst_mty: got %b expected 1", mty_a); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_even_parity();
    test_back_to_back();
    test_overflow();
    test_odd_parity_5bit();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_tx_fifo
`default_nettype wire
